// File: rtl/adder_multiop_pipe_pkg.sv
// rtl/adder_multiop_pipe_pkg.sv - shared constants and elaboration helpers for the multi-operand adder
package adder_multiop_pipe_pkg;

    localparam int SHA256_WORD_W = 32;

    function automatic int clog2(input int n);
        int c = 0;
        while ((1 << c) < n) c++;
        return c;
    endfunction

    // Rows left after one 3:2 level: each full triple becomes two, leftovers pass through.
    function automatic int csa_next(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int csa_rows(input int n_ops, input int lvl);
        int n = n_ops;
        for (int i = 0; i < lvl; i++) n = csa_next(n);
        return n;
    endfunction

    function automatic int csa_levels(input int n_ops);
        int n = n_ops;
        int l = 0;
        while (n > 2) begin
            n = csa_next(n);
            l++;
        end
        return l;
    endfunction

    function automatic int seg_start(input int j, input int nl, input int nb);
        return (nb == 0) ? 0 : (j * nl) / nb;
    endfunction

    function automatic int seg_end(input int j, input int nl, input int nb);
        return (nb == 0) ? nl : ((j + 1) * nl) / nb;
    endfunction

    function automatic int seg_of(input int l, input int nl, input int nb);
        int s = 0;
        for (int j = nb - 1; j >= 0; j--) if (seg_end(j, nl, nb) > l) s = j;
        return s;
    endfunction

    // Bit offset of level l's output rows inside the flat level vector.
    function automatic int lvl_off(input int n_ops, input int l, input int sw);
        int o = 0;
        for (int i = 0; i < l; i++) o += csa_rows(n_ops, i + 1) * sw;
        return o;
    endfunction

    // Bit offset of stage s's registered rows inside the flat stage register.
    function automatic int reg_off(input int n_ops, input int s, input int nl, input int nb,
                                   input int sw);
        int o = 0;
        for (int j = 0; j < s; j++) o += csa_rows(n_ops, seg_end(j, nl, nb)) * sw;
        return o;
    endfunction

endpackage

// File: rtl/adder_multiop_pipe_csa_3to2.sv
// rtl/adder_multiop_pipe_csa_3to2.sv - one row of full adders reducing three vectors to two
module adder_multiop_pipe_csa_3to2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[WIDTH-2:0] & b[WIDTH-2:0]) | (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                    (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/adder_multiop_pipe.sv
// rtl/adder_multiop_pipe.sv - pipelined N-operand adder: CSA tree, final CPA, valid/ready, tag passthrough
module adder_multiop_pipe
    import adder_multiop_pipe_pkg::*;
#(
    parameter int  WIDTH  = SHA256_WORD_W,
    parameter int  N_OPS  = 5,
    parameter int  STAGES = 2,
    parameter int  TAG_W  = 4,
    localparam int CW     = clog2(N_OPS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [N_OPS*WIDTH-1:0] i_ops,
    input  logic [N_OPS-1:0]       i_mask,
    input  logic [TAG_W-1:0]       i_tag,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_summ,
    output logic [CW-1:0]          o_carry,
    output logic [TAG_W-1:0]       o_tag
);

    localparam int SW     = WIDTH + CW;
    localparam int NL     = csa_levels(N_OPS);
    localparam int NB     = STAGES - 1;
    localparam int NB1    = (NB > 0) ? NB : 1;
    localparam int RW_IN  = N_OPS * SW;
    localparam int LV_W   = (NL > 0) ? lvl_off(N_OPS, NL, SW) : 1;
    localparam int ROWS_W = (NB > 0) ? reg_off(N_OPS, NB, NL, NB, SW) : 1;

    logic                adv;
    logic [RW_IN-1:0]    masked;
    logic [LV_W-1:0]     lv;
    logic [ROWS_W-1:0]   stage_rows;
    logic [ROWS_W-1:0]   row_ld;
    logic [ROWS_W-1:0]   rows_d, rows_q;
    logic [NB1-1:0]      vld_d, vld_q;
    logic [TAG_W-1:0]    tag_d [NB1];
    logic [TAG_W-1:0]    tag_q [NB1];
    logic [NB:0]         vin_chain;
    logic [TAG_W-1:0]    tag_chain [NB+1];
    logic [2*SW-1:0]     cpa_in;
    logic [SW-1:0]       cpa_sum;
    logic                out_vld_d, out_vld_q;
    logic [SW-1:0]       out_sum_d, out_sum_q;
    logic [TAG_W-1:0]    out_tag_d, out_tag_q;

    // Global stall: every stage advances together or not at all.
    assign adv     = !out_vld_q || i_ready;
    assign o_ready = adv;

    always_comb begin
        masked = '0;
        for (int k = 0; k < N_OPS; k++) begin
            if (i_mask[k]) masked[k*SW +: SW] = SW'(i_ops[k*WIDTH +: WIDTH]);
        end
    end

    for (genvar l = 0; l < NL; l++) begin : g_lvl
        localparam int J   = seg_of(l, NL, NB);
        localparam int NI  = csa_rows(N_OPS, l);
        localparam int Q   = NI / 3;
        localparam int OFF = lvl_off(N_OPS, l, SW);
        logic [NI*SW-1:0] x;

        if (l != seg_start(J, NL, NB)) begin : g_chain
            assign x = lv[lvl_off(N_OPS, l - 1, SW) +: NI*SW];
        end else if (J == 0) begin : g_in
            assign x = masked;
        end else begin : g_reg
            assign x = rows_q[reg_off(N_OPS, J - 1, NL, NB, SW) +: NI*SW];
        end

        for (genvar g = 0; g < Q; g++) begin : g_csa
            adder_multiop_pipe_csa_3to2 #(.WIDTH(SW)) u_csa (
                .a     (x[(3*g)*SW +: SW]),
                .b     (x[(3*g+1)*SW +: SW]),
                .c     (x[(3*g+2)*SW +: SW]),
                .sum   (lv[OFF + (2*g)*SW +: SW]),
                .carry (lv[OFF + (2*g+1)*SW +: SW])
            );
        end

        for (genvar r = 0; r < NI % 3; r++) begin : g_pass
            assign lv[OFF + (2*Q+r)*SW +: SW] = x[(3*Q+r)*SW +: SW];
        end
    end

    // An empty segment (fewer levels than boundaries) is a plain delay register.
    for (genvar s = 0; s < NB; s++) begin : g_stage
        localparam int NR   = csa_rows(N_OPS, seg_end(s, NL, NB));
        localparam int ROFF = reg_off(N_OPS, s, NL, NB, SW);

        if (seg_end(s, NL, NB) > seg_start(s, NL, NB)) begin : g_tree
            assign stage_rows[ROFF +: NR*SW] = lv[lvl_off(N_OPS, seg_end(s, NL, NB) - 1, SW) +: NR*SW];
        end else if (s == 0) begin : g_in
            assign stage_rows[ROFF +: NR*SW] = masked;
        end else begin : g_fwd
            assign stage_rows[ROFF +: NR*SW] = rows_q[reg_off(N_OPS, s - 1, NL, NB, SW) +: NR*SW];
        end
        assign row_ld[ROFF +: NR*SW] = {(NR*SW){adv & vin_chain[s]}};
    end

    if (NB == 0) begin : g_no_stage
        assign stage_rows = '0;
        assign row_ld     = '0;
    end

    if (NB > 0) begin : g_cpa_reg
        assign cpa_in = rows_q[ROWS_W-1 -: 2*SW];
    end else if (NL > 0) begin : g_cpa_tree
        assign cpa_in = lv[LV_W-1 -: 2*SW];
    end else begin : g_cpa_in
        assign cpa_in = masked;
    end

    assign cpa_sum = cpa_in[SW-1:0] + cpa_in[2*SW-1:SW];

    always_comb begin
        vin_chain    = '0;
        vin_chain[0] = i_valid;
        tag_chain[0] = i_tag;
        for (int s = 0; s < NB; s++) begin
            vin_chain[s+1] = vld_q[s];
            tag_chain[s+1] = tag_q[s];
        end

        rows_d = (stage_rows & row_ld) | (rows_q & ~row_ld);
        vld_d  = vld_q;
        for (int s = 0; s < NB1; s++) tag_d[s] = tag_q[s];
        for (int s = 0; s < NB; s++) begin
            vld_d[s] = adv ? vin_chain[s] : vld_q[s];
            if (adv && vin_chain[s]) tag_d[s] = tag_chain[s];
        end

        out_vld_d = adv ? vin_chain[NB] : out_vld_q;
        out_sum_d = (adv && vin_chain[NB]) ? cpa_sum       : out_sum_q;
        out_tag_d = (adv && vin_chain[NB]) ? tag_chain[NB] : out_tag_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rows_q    <= '0;
            vld_q     <= '0;
            for (int s = 0; s < NB1; s++) tag_q[s] <= '0;
            out_vld_q <= 1'b0;
            out_sum_q <= '0;
            out_tag_q <= '0;
        end else begin
            rows_q    <= rows_d;
            vld_q     <= vld_d;
            for (int s = 0; s < NB1; s++) tag_q[s] <= tag_d[s];
            out_vld_q <= out_vld_d;
            out_sum_q <= out_sum_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign o_valid = out_vld_q;
    assign o_summ  = out_sum_q[WIDTH-1:0];
    assign o_carry = out_sum_q[SW-1:WIDTH];
    assign o_tag   = out_tag_q;

endmodule
